// File: rtl/fifo_stream_reader_if.sv
// Packed-word stream between the FIFO reader and the next stage.
// Master drives word/count/valid, slave returns ready.
interface fifo_stream_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4,
  parameter int LOG_PACK   = 2
);
  logic [DATA_WIDTH*PACK-1:0] out_data;
  logic [LOG_PACK:0]          out_count;
  logic                       out_valid;
  logic                       out_ready;

  modport master (
    output out_data,
    output out_count,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_count,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a FIFO head, packs PACK entries per word, emits on a stream.
// Flush closes a partial word; unused lanes read as zero.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4,
  parameter int LOG_PACK   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  fifo_next_read,
  input  logic                  flush,
  output logic                  busy,
  fifo_stream_reader_if.master  out_if
);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam logic [LOG_PACK:0] LAST =
    (LOG_PACK+1)'(PACK-1);
  localparam logic [LOG_PACK:0] FULL =
    (LOG_PACK+1)'(PACK);

  state_e state_q, state_d;
  logic [LOG_PACK:0] idx_q, idx_d;
  logic [LOG_PACK:0] cnt_q, cnt_d;
  logic [LOG_PACK:0] eff;
  logic [PACK-1:0][DATA_WIDTH-1:0] lanes_q;
  logic [PACK-1:0][DATA_WIDTH-1:0] lanes_d;
  logic pend_q, pend_d;
  logic pop;
  logic flush_req;

  // Pop only while filling; held words block the FIFO.
  assign pop = (state_q == FILL)
             & ~fifo_empty & ~rst;
  assign fifo_next_read = pop;

  // Lanes valid once the current edge lands.
  assign eff = idx_q
             + {{LOG_PACK{1'b0}}, pop};
  assign flush_req = flush | pend_q;

  // Next-state: lane capture, word close, flush deferral.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    lanes_d = lanes_q;
    pend_d  = pend_q;
    unique case (state_q)
      FILL: begin
        if (pop) begin
          for (int i = 0; i < PACK; i++) begin
            if (idx_q == (LOG_PACK+1)'(i)) begin
              lanes_d[i] = fifo_data;
            end
          end
          idx_d = eff;
        end
        if (pop && idx_q == LAST) begin
          // A flush on the filling pop is absorbed.
          state_d = HOLD;
          cnt_d   = FULL;
          pend_d  = 1'b0;
        end else if (flush_req && eff != '0) begin
          state_d = HOLD;
          cnt_d   = eff;
          pend_d  = 1'b0;
        end else if (flush_req) begin
          // Nothing to emit: drop it.
          pend_d = 1'b0;
        end
      end
      HOLD: begin
        if (flush) begin
          pend_d = 1'b1;
        end
        if (out_if.out_ready) begin
          state_d = FILL;
          idx_d   = '0;
          lanes_d = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      idx_q   <= '0;
      cnt_q   <= '0;
      lanes_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      lanes_q <= lanes_d;
      pend_q  <= pend_d;
    end
  end

  assign out_if.out_data  = lanes_q;
  assign out_if.out_count = cnt_q;
  assign out_if.out_valid = (state_q == HOLD);

  assign busy = (idx_q != '0)
              | (state_q == HOLD)
              | pend_q;

endmodule
